// File: rtl/stoch_stream_counter_pkg.sv
// Shared definitions for the stochastic-to-binary stream counter and its sibling
// stochastic-number-generator blocks: FSM encoding, window range check, bipolar offset.
package stoch_stream_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int WIN_BITS_MIN = 2;
    localparam int WIN_BITS_MAX = 16;

    function automatic bit win_bits_legal(input int w);
        return (w >= WIN_BITS_MIN) && (w <= WIN_BITS_MAX);
    endfunction

    // Zero point of a bipolar stream over a 2^w window: value = 2*ones - 2^w.
    function automatic int unsigned bipolar_offset(input int w);
        return 32'd1 << w;
    endfunction

endpackage

// File: rtl/stoch_stream_counter_if.sv
// Bundle of control, sample and result signals between the OR-summation/host side
// (master) and the stream counter (slave).
interface stoch_stream_counter_if #(
    parameter int OUT_W = 10
);
    // Result handshake: count_valid rises with a finished window and stays high, with
    // count held stable, until a cycle where count_valid & count_ready are both high;
    // that cycle is the transfer. count_ready has no effect while count_valid is low.
    logic             start;
    logic             clear;
    logic             bit_in;
    logic             bit_valid;
    logic             count_ready;
    logic [OUT_W-1:0] count;
    logic             count_valid;
    logic             busy;

    modport master (
        output start, clear, bit_in, bit_valid, count_ready,
        input  count, count_valid, busy
    );

    modport slave (
        input  start, clear, bit_in, bit_valid, count_ready,
        output count, count_valid, busy
    );
endinterface

// File: rtl/stoch_stream_counter_window_timer.sv
// Counts qualified samples within a 2^WIN_BITS window and strobes on the last one.
// The strobe is combinational so the owner can capture its final result on the same edge.
module stoch_window_timer #(
    parameter int WIN_BITS = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);
    localparam logic [WIN_BITS:0] LAST_IDX = {1'b0, {WIN_BITS{1'b1}}};

    logic [WIN_BITS:0] r_samples;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_samples <= '0;
        end else if (i_clr) begin
            r_samples <= '0;
        end else if (i_en) begin
            r_samples <= r_samples + 1'b1;
        end
    end

    assign o_last = i_en && !i_clr && (r_samples == LAST_IDX);

endmodule

// File: rtl/stoch_stream_counter.sv
// Converts an OR-summed stochastic bitstream into a binary count of ones over a window
// of 2^WIN_BITS valid samples, unipolar or bipolar, delivered on a valid/ready handshake.
module stoch_stream_counter
    import stoch_stream_counter_pkg::*;
#(
    parameter int WIN_BITS = 8,
    parameter bit BIPOLAR  = 1'b0,
    localparam int OUT_W   = WIN_BITS + 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    stoch_stream_counter_if.slave  io_if,
    output state_t                 o_dbg_state
);

    if (!win_bits_legal(WIN_BITS)) begin : g_bad_win_bits
        $error("stoch_stream_counter: WIN_BITS must be within 2..16");
    end

    state_t             r_state;
    logic [WIN_BITS:0]  r_acc;
    logic [OUT_W-1:0]   r_count;
    logic               r_count_valid;
    logic               r_busy;

    logic               w_start_ok;
    logic               w_tmr_clr;
    logic               w_tmr_en;
    logic               w_last;
    logic [WIN_BITS:0]  w_acc_next;
    logic [OUT_W-1:0]   w_acc_ext;
    logic [OUT_W-1:0]   w_result;

    // START only counts when the counter can actually begin a fresh window.
    assign w_start_ok = io_if.start &&
                        ((r_state == ST_IDLE) ||
                         ((r_state == ST_HOLD) && io_if.count_ready));
    assign w_tmr_clr  = io_if.clear || w_start_ok;
    assign w_tmr_en   = (r_state == ST_ACCUM) && io_if.bit_valid;

    stoch_window_timer #(
        .WIN_BITS (WIN_BITS)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .o_last  (w_last)
    );

    assign w_acc_next = r_acc + {{WIN_BITS{1'b0}}, io_if.bit_in};
    assign w_acc_ext  = {1'b0, w_acc_next};

    if (BIPOLAR) begin : g_bipolar
        localparam logic [OUT_W-1:0] OFFSET = OUT_W'(bipolar_offset(WIN_BITS));
        assign w_result = (w_acc_ext << 1) - OFFSET;
    end else begin : g_unipolar
        assign w_result = w_acc_ext;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_acc         <= '0;
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else if (io_if.clear) begin
            // COUNT deliberately keeps its last value across an abort.
            r_state       <= ST_IDLE;
            r_count_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_if.start) begin
                        r_state <= ST_ACCUM;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (io_if.bit_valid) begin
                        r_acc <= w_acc_next;
                    end
                    if (w_last) begin
                        r_state       <= ST_HOLD;
                        r_count       <= w_result;
                        r_count_valid <= 1'b1;
                        r_busy        <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (io_if.count_ready) begin
                        r_count_valid <= 1'b0;
                        if (io_if.start) begin
                            r_state <= ST_ACCUM;
                            r_acc   <= '0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_count_valid <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign io_if.count       = r_count;
    assign io_if.count_valid = r_count_valid;
    assign io_if.busy        = r_busy;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_stoch_stream_counter.sv
// Directed-plus-random bench for stoch_stream_counter: a unipolar and a bipolar
// instance see identical stimulus and are checked against a ones-count reference.
module tb_stoch_stream_counter;
    import stoch_stream_counter_pkg::*;

    localparam int WB    = 4;
    localparam int WIN   = 1 << WB;
    localparam int OW    = WB + 2;

    logic   clk;
    logic   rst_n;
    state_t uni_state;
    state_t bip_state;

    int checks = 0;
    int errors = 0;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] last_e;

    stoch_stream_counter_if #(.OUT_W(OW)) uni_if ();
    stoch_stream_counter_if #(.OUT_W(OW)) bip_if ();

    stoch_stream_counter #(.WIN_BITS(WB), .BIPOLAR(1'b0)) u_uni (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .io_if       (uni_if.slave),
        .o_dbg_state (uni_state)
    );

    stoch_stream_counter #(.WIN_BITS(WB), .BIPOLAR(1'b1)) u_bip (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .io_if       (bip_if.slave),
        .o_dbg_state (bip_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bits(input logic s, input logic v, input logic b);
        uni_if.start = s;     bip_if.start = s;
        uni_if.bit_valid = v; bip_if.bit_valid = v;
        uni_if.bit_in = b;    bip_if.bit_in = b;
    endtask

    task automatic set_ready(input logic r);
        uni_if.count_ready = r;
        bip_if.count_ready = r;
    endtask

    task automatic set_clear(input logic c);
        uni_if.clear = c;
        bip_if.clear = c;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] bip_of(input logic [OW-1:0] ones);
        return OW'((2 * int'(ones)) - WIN);
    endfunction

    task automatic start_window();
        drive_bits(1'b1, 1'b0, 1'b0);
        tick();
        drive_bits(1'b0, 1'b0, 1'b0);
        check("start_busy", {31'd0, uni_if.busy}, 32'd1);
        check("start_valid_low", {31'd0, bip_if.count_valid}, 32'd0);
    endtask

    // style 0 random (with ignored START pulses), 1 all ones, 2 all zeros,
    // 3 alternating with every third cycle a gap carrying BIT_IN=1, 4 twelve ones.
    task automatic feed_window(input int style);
        int   nv = 0;
        int   ones = 0;
        int   cyc = 0;
        logic v, b, s;
        while (nv < WIN && cyc < 200) begin
            s = 1'b0;
            case (style)
                0: begin
                    v = ($urandom_range(0, 3) != 0);
                    b = 1'($urandom_range(0, 1));
                    s = ($urandom_range(0, 7) == 0);
                end
                1: begin v = 1'b1; b = 1'b1; end
                2: begin v = 1'b1; b = 1'b0; end
                3: begin
                    v = ((cyc % 3) != 2);
                    b = v ? ((nv % 2) == 0) : 1'b1;
                end
                default: begin v = 1'b1; b = (nv < 12); end
            endcase
            drive_bits(s, v, b);
            if (v) begin
                nv++;
                ones += int'(b);
            end
            cyc++;
            tick();
            if (nv < WIN) begin
                check("accum_valid_low", {31'd0, uni_if.count_valid}, 32'd0);
                check("accum_busy", {31'd0, bip_if.busy}, 32'd1);
            end
        end
        check("window_samples", nv, WIN);
        exp_q.push_back(OW'(ones));
        drive_bits(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_result();
        logic [OW-1:0] e;
        check("sb_size", exp_q.size(), 1);
        e = exp_q.pop_front();
        check("uni_valid", {31'd0, uni_if.count_valid}, 32'd1);
        check("bip_valid", {31'd0, bip_if.count_valid}, 32'd1);
        check("hold_busy", {31'd0, uni_if.busy}, 32'd0);
        check("uni_count", 32'(uni_if.count), 32'(e));
        check("bip_count", 32'(bip_if.count), 32'(bip_of(e)));
        last_e = e;
    endtask

    task automatic finish_ready();
        set_ready(1'b1);
        tick();
        check("handshake_valid_low", {31'd0, uni_if.count_valid}, 32'd0);
        check("handshake_bip_valid_low", {31'd0, bip_if.count_valid}, 32'd0);
        check("handshake_idle_busy", {31'd0, uni_if.busy}, 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n = 1'b0;
        last_e = '0;
        drive_bits(1'b0, 1'b0, 1'b0);
        set_ready(1'b0);
        set_clear(1'b0);
        tick();
        tick();
        check("rst_uni_count", 32'(uni_if.count), 32'd0);
        check("rst_bip_count", 32'(bip_if.count), 32'd0);
        check("rst_valid", {31'd0, uni_if.count_valid}, 32'd0);
        check("rst_busy", {31'd0, uni_if.busy}, 32'd0);
        check("rst_state", 32'(uni_state), 32'(ST_IDLE));
        #4 rst_n = 1'b1;
        tick();
        check("idle_busy", {31'd0, bip_if.busy}, 32'd0);

        // all ones, consumer ready throughout
        set_ready(1'b1);
        start_window();
        feed_window(1);
        check_result();
        finish_ready();

        // alternating with gaps
        start_window();
        feed_window(3);
        check_result();
        finish_ready();

        // all zeros, then twelve ones
        start_window();
        feed_window(2);
        check_result();
        finish_ready();
        start_window();
        feed_window(4);
        check_result();
        finish_ready();

        // stalled consumer, START during HOLD ignored, then back-to-back
        set_ready(1'b0);
        start_window();
        feed_window(1);
        check_result();
        for (int i = 0; i < 10; i++) begin
            drive_bits((i == 4), 1'($urandom_range(0, 1)), 1'b1);
            tick();
            check("stall_valid", {31'd0, uni_if.count_valid}, 32'd1);
            check("stall_busy", {31'd0, uni_if.busy}, 32'd0);
            check("stall_uni_count", 32'(uni_if.count), 32'(last_e));
            check("stall_bip_count", 32'(bip_if.count), 32'(bip_of(last_e)));
        end
        set_ready(1'b1);
        drive_bits(1'b1, 1'b0, 1'b0);
        tick();
        drive_bits(1'b0, 1'b0, 1'b0);
        set_ready(1'b0);
        check("b2b_valid_low", {31'd0, uni_if.count_valid}, 32'd0);
        check("b2b_busy", {31'd0, uni_if.busy}, 32'd1);
        feed_window(0);
        check_result();
        finish_ready();

        // CLEAR mid-window: no result, COUNT keeps last value, no residue afterwards
        start_window();
        for (int i = 0; i < 7; i++) begin
            drive_bits(1'b0, 1'b1, 1'b1);
            tick();
        end
        drive_bits(1'b0, 1'b0, 1'b0);
        set_clear(1'b1);
        tick();
        set_clear(1'b0);
        check("clear_busy", {31'd0, uni_if.busy}, 32'd0);
        check("clear_valid", {31'd0, uni_if.count_valid}, 32'd0);
        check("clear_uni_count_kept", 32'(uni_if.count), 32'(last_e));
        check("clear_bip_count_kept", 32'(bip_if.count), 32'(bip_of(last_e)));
        tick();
        check("clear_no_valid", {31'd0, bip_if.count_valid}, 32'd0);
        start_window();
        feed_window(1);
        check_result();
        finish_ready();

        // random windows with random consumer delay
        for (int k = 0; k < 6; k++) begin
            set_ready(1'($urandom_range(0, 1)));
            start_window();
            feed_window(0);
            check_result();
            set_ready(1'b0);
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
                tick();
                check("rand_hold_valid", {31'd0, uni_if.count_valid}, 32'd1);
                check("rand_hold_count", 32'(uni_if.count), 32'(last_e));
            end
            finish_ready();
        end

        // async reset mid-window (with an ignored START inside ACCUM)
        start_window();
        for (int i = 0; i < 5; i++) begin
            drive_bits((i == 2), 1'b1, 1'b1);
            tick();
        end
        drive_bits(1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_accum_busy", {31'd0, uni_if.busy}, 32'd0);
        check("arst_accum_valid", {31'd0, uni_if.count_valid}, 32'd0);
        check("arst_accum_uni_count", 32'(uni_if.count), 32'd0);
        check("arst_accum_bip_count", 32'(bip_if.count), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("arst_no_valid", {31'd0, uni_if.count_valid}, 32'd0);

        // async reset mid-HOLD
        set_ready(1'b0);
        start_window();
        feed_window(1);
        check_result();
        #3 rst_n = 1'b0;
        #1;
        check("arst_hold_valid", {31'd0, bip_if.count_valid}, 32'd0);
        check("arst_hold_uni_count", 32'(uni_if.count), 32'd0);
        check("arst_hold_bip_count", 32'(bip_if.count), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        start_window();
        feed_window(0);
        check_result();
        finish_ready();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
